// File: rtl/roi_pixel_capture.sv
// roi_pixel_capture: captures ADC pixels on falling edges of a registered ROI
// readout clock, tags start-of-frame / end-of-line, and streams them out
// through a first-word-fall-through FIFO with sticky overflow/error flags.
//
// Output handshake: a beat transfers on a clock edge where m_tvalid_o and
// m_tready_i are both high; while m_tvalid_o=1 and m_tready_i=0 the beat
// (m_tdata_o/m_tuser_o/m_tlast_o) is held unchanged.
module roi_pixel_capture #(
   parameter int DATA_WIDTH = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          capture_en_i,
   input  logic                          clr_i,
   input  logic [9:0]                    cfg_cols_i,
   input  logic [9:0]                    cfg_rows_i,
   input  logic                          sns_clk_roi_i,
   input  logic                          sns_enable_roi_i,
   input  logic [DATA_WIDTH-1:0]         adc_data_i,
   output logic [15:0]                   m_tdata_o,
   output logic                          m_tvalid_o,
   input  logic                          m_tready_i,
   output logic                          m_tuser_o,
   output logic                          m_tlast_o,
   output logic                          frame_done_o,
   output logic [15:0]                   frame_cnt_o,
   output logic                          ovf_o,
   output logic                          err_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic [1:0]                    deb_state_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = DATA_WIDTH + 2;
   localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);
   localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_ACTIVE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_roi_q;
   logic [9:0]      r_cols;
   logic [9:0]      r_rows;
   logic [9:0]      r_col;
   logic [9:0]      r_row;
   logic            r_full;        // every cols*rows pixel of this frame seen
   logic            r_frame_done;
   logic [15:0]     r_frame_cnt;
   logic            r_ovf;
   logic            r_err;
   logic [FW-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;

   logic            w_evt;
   logic            w_pix_first;
   logic            w_pix_next;
   logic            w_pix;
   logic            w_keep;
   logic            w_short;
   logic [9:0]      w_cols;
   logic [9:0]      w_rows;
   logic            w_last_col;
   logic            w_last_row;
   logic            w_fifo_full;
   logic            w_wr;
   logic            w_rd;
   logic [FW-1:0]   w_head;

   // Sample event: ROI clock was high last cycle and is low now.
   assign w_evt       = r_roi_q & ~sns_clk_roi_i;
   assign w_pix_first = capture_en_i && (r_state == S_ARMED)  && w_evt && sns_enable_roi_i;
   assign w_pix_next  = capture_en_i && (r_state == S_ACTIVE) && w_evt && sns_enable_roi_i;
   assign w_pix       = w_pix_first | w_pix_next;
   assign w_short     = capture_en_i && (r_state == S_ACTIVE) && w_evt &&
                        !sns_enable_roi_i && !r_full;

   // The first pixel uses the live config (it is being latched this cycle);
   // a zero geometry value behaves as one.
   assign w_cols = (r_state == S_ARMED) ? ((cfg_cols_i == 10'd0) ? 10'd1 : cfg_cols_i) : r_cols;
   assign w_rows = (r_state == S_ARMED) ? ((cfg_rows_i == 10'd0) ? 10'd1 : cfg_rows_i) : r_rows;

   // Counters are zero whenever ARMED, so r_col/r_row are valid for the first pixel too.
   assign w_last_col  = (r_col == (w_cols - 10'd1));
   assign w_last_row  = (r_row == (w_rows - 10'd1));
   assign w_keep      = w_pix & ~r_full;

   assign w_fifo_full = (r_count == LP_DEPTH);
   assign w_wr        = w_keep & ~w_fifo_full;
   assign w_rd        = (r_count != '0) & m_tready_i;
   assign w_head      = r_mem[r_rd_ptr];

   assign m_tvalid_o   = (r_count != '0);
   assign m_tdata_o    = m_tvalid_o ? 16'(w_head[DATA_WIDTH-1:0]) : 16'd0;
   assign m_tuser_o    = m_tvalid_o & w_head[FW-1];
   assign m_tlast_o    = m_tvalid_o & w_head[FW-2];
   assign fifo_level_o = r_count;
   assign frame_done_o = r_frame_done;
   assign frame_cnt_o  = r_frame_cnt;
   assign ovf_o        = r_ovf;
   assign err_o        = r_err;
   assign deb_state_o  = r_state;

   // ROI clock edge-detect register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_roi_q <= 1'b0;
      else          r_roi_q <= sns_clk_roi_i;
   end

   // Capture FSM with frame-done pulse, frame counter and geometry latch.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= S_IDLE;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= 16'd0;
         r_cols       <= 10'd1;
         r_rows       <= 10'd1;
      end else begin
         r_frame_done <= 1'b0;
         if (!capture_en_i) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE:   r_state <= S_ARMED;
               S_ARMED: begin
                  if (w_pix_first) begin
                     r_state <= S_ACTIVE;
                     r_cols  <= w_cols;
                     r_rows  <= w_rows;
                  end
               end
               S_ACTIVE: begin
                  if (w_evt && !sns_enable_roi_i) begin
                     r_state      <= S_DONE;
                     r_frame_done <= 1'b1;
                     r_frame_cnt  <= r_frame_cnt + 16'd1;
                  end
               end
               default:  r_state <= S_ARMED;
            endcase
         end
      end
   end

   // Column/row position within the frame; cleared between frames.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_col  <= 10'd0;
         r_row  <= 10'd0;
         r_full <= 1'b0;
      end else if (!capture_en_i || (r_state == S_IDLE) || (r_state == S_DONE)) begin
         r_col  <= 10'd0;
         r_row  <= 10'd0;
         r_full <= 1'b0;
      end else if (w_keep) begin
         if (w_last_col) begin
            r_col <= 10'd0;
            r_row <= r_row + 10'd1;
            if (w_last_row) r_full <= 1'b1;
         end else begin
            r_col <= r_col + 10'd1;
         end
      end
   end

   // Sticky status: a set event in the same cycle as clr_i wins.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ovf <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_ovf <= (w_keep & w_fifo_full) | (r_ovf & ~clr_i);
         r_err <= (w_pix & r_full) | w_short | (r_err & ~clr_i);
      end
   end

   // FIFO storage; entry = {tuser, tlast, data}.
   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_wr_ptr] <= {(r_state == S_ARMED), w_last_col, adc_data_i};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
         if (w_rd) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + LP_CNT_ONE;
            2'b01:   r_count <= r_count - LP_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_roi_pixel_capture.sv
// Bench for roi_pixel_capture: drives ROI-clocked frames, keeps a queue of
// expected output beats from frame geometry, and compares every presented beat.
module tb_roi_pixel_capture;

   localparam int DW    = 12;
   localparam int DEPTH = 16;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        capture_en_i = 1'b0;
   logic        clr_i = 1'b0;
   logic [9:0]  cfg_cols_i = 10'd4;
   logic [9:0]  cfg_rows_i = 10'd2;
   logic        sns_clk_roi_i = 1'b0;
   logic        sns_enable_roi_i = 1'b0;
   logic [DW-1:0] adc_data_i = '0;
   logic        m_tready_i = 1'b0;
   logic [15:0] m_tdata_o;
   logic        m_tvalid_o;
   logic        m_tuser_o;
   logic        m_tlast_o;
   logic        frame_done_o;
   logic [15:0] frame_cnt_o;
   logic        ovf_o;
   logic        err_o;
   logic [4:0]  fifo_level_o;
   logic [1:0]  deb_state_o;

   roi_pixel_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .capture_en_i(capture_en_i), .clr_i(clr_i),
      .cfg_cols_i(cfg_cols_i), .cfg_rows_i(cfg_rows_i),
      .sns_clk_roi_i(sns_clk_roi_i), .sns_enable_roi_i(sns_enable_roi_i),
      .adc_data_i(adc_data_i),
      .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
      .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o),
      .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
      .ovf_o(ovf_o), .err_o(err_o), .fifo_level_o(fifo_level_o),
      .deb_state_o(deb_state_o)
   );

   // clock
   always #5 clk_i = ~clk_i;

   // scoreboard state: beats as {tuser, tlast, tdata[15:0]}
   logic [17:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int fk, fcols, frows;
   int exp_frames = 0;
   int seen_done = 0;
   logic exp_err = 1'b0;
   logic exp_ovf = 1'b0;
   int rdy_mode = 1;   // 0 random, 1 always, 2 never, 3 toggle

   // downstream ready pattern
   always @(posedge clk_i) begin
      #1;
      case (rdy_mode)
         0:       m_tready_i = 1'($urandom_range(0, 1));
         1:       m_tready_i = 1'b1;
         2:       m_tready_i = 1'b0;
         default: m_tready_i = ~m_tready_i;
      endcase
   end

   // monitor: every presented beat must equal the queue head; pop on transfer
   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (frame_done_o) seen_done++;
         if (m_tvalid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat act=%h expected none", {m_tuser_o, m_tlast_o, m_tdata_o});
            end else begin
               if ({m_tuser_o, m_tlast_o, m_tdata_o} !== exp_q[0]) begin
                  errors++;
                  $display("FAIL beat act=%h exp=%h", {m_tuser_o, m_tlast_o, m_tdata_o}, exp_q[0]);
               end
               if (m_tready_i) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // reference model: pixel k of a cols x rows frame
   task automatic model_pixel(input logic [DW-1:0] d);
      if (fk < fcols * frows) begin
         if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
         else exp_q.push_back({(fk == 0), ((fk % fcols) == fcols - 1), 16'(d)});
      end else begin
         exp_err = 1'b1;
      end
      fk++;
   endtask

   task automatic start_frame(input int c, input int r);
      cfg_cols_i = 10'(c);
      cfg_rows_i = 10'(r);
      fcols = (c == 0) ? 1 : c;
      frows = (r == 0) ? 1 : r;
      fk = 0;
   endtask

   task automatic send_pixel(input logic [DW-1:0] d);
      sns_enable_roi_i = 1'b1;
      adc_data_i = d;
      sns_clk_roi_i = 1'b1;
      tick();
      sns_clk_roi_i = 1'b0;
      model_pixel(d);
      tick();
      repeat ($urandom_range(0, 1)) tick();
   endtask

   task automatic end_frame();
      sns_enable_roi_i = 1'b0;
      sns_clk_roi_i = 1'b1;
      tick();
      sns_clk_roi_i = 1'b0;
      if (fk < fcols * frows) exp_err = 1'b1;
      exp_frames++;
      tick();
      tick();
      tick();
   endtask

   task automatic frame_checks(input string tag);
      chk({tag, "_frame_cnt"}, frame_cnt_o, exp_frames[15:0]);
      chk({tag, "_done_pulses"}, seen_done, exp_frames);
      chk({tag, "_err"}, err_o, exp_err);
      chk({tag, "_ovf"}, ovf_o, exp_ovf);
   endtask

   task automatic clear_flags();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      exp_err = 1'b0;
      exp_ovf = 1'b0;
      tick();
      chk("clr_err", err_o, 1'b0);
      chk("clr_ovf", ovf_o, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      tick();
      tick();
      chk("drain_queue_left", exp_q.size(), 0);
      chk("drain_level", fifo_level_o, 0);
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_tvalid", m_tvalid_o, 0);
      chk("rst_level", fifo_level_o, 0);
      chk("rst_state", deb_state_o, 0);
      chk("rst_frame_cnt", frame_cnt_o, 0);
      chk("rst_flags", {ovf_o, err_o, frame_done_o, m_tuser_o, m_tlast_o}, 0);
      #10 rst_n_i = 1'b1;
      tick();
      capture_en_i = 1'b1;
      tick();
      tick();
      chk("armed", deb_state_o, 1);

      // basic 4x2 frame, data 1..8, always ready
      rdy_mode = 1;
      start_frame(4, 2);
      for (int i = 1; i <= 8; i++) send_pixel(DW'(i));
      end_frame();
      drain();
      frame_checks("basic");

      // toggling ready
      rdy_mode = 3;
      start_frame(4, 2);
      for (int i = 0; i < 8; i++) send_pixel(DW'($urandom));
      end_frame();
      drain();
      frame_checks("toggle");

      // short frame of 5 pixels
      rdy_mode = 1;
      start_frame(4, 2);
      for (int i = 0; i < 5; i++) send_pixel(DW'($urandom));
      end_frame();
      drain();
      frame_checks("short");
      clear_flags();

      // stalled output: 20 pixels over frames of 8, 8, 4
      rdy_mode = 2;
      for (int f = 0; f < 3; f++) begin
         start_frame(4, 2);
         for (int i = 0; i < ((f == 2) ? 4 : 8); i++) send_pixel(DW'($urandom));
         end_frame();
      end
      chk("stall_level", fifo_level_o, exp_q.size());
      frame_checks("stall");
      rdy_mode = 1;
      drain();
      clear_flags();

      // zero column config treated as one column
      start_frame(0, 3);
      for (int i = 0; i < 3; i++) send_pixel(DW'($urandom));
      end_frame();
      drain();
      frame_checks("cols0");

      // random geometry, length and ready pattern; config changes after latch
      rdy_mode = 0;
      for (int f = 0; f < 10; f++) begin
         int c, r, n;
         c = $urandom_range(0, 6);
         r = $urandom_range(1, 4);
         start_frame(c, r);
         n = fcols * frows + $urandom_range(0, 4) - 2;
         if (n < 1) n = 1;
         for (int i = 0; i < n; i++) begin
            send_pixel(DW'($urandom));
            if (i == 0) begin
               cfg_cols_i = 10'($urandom_range(1, 9));
               cfg_rows_i = 10'($urandom_range(1, 9));
            end
         end
         end_frame();
         frame_checks("rand");
         clear_flags();
      end
      rdy_mode = 1;
      drain();

      // capture disabled mid-frame
      rdy_mode = 2;
      start_frame(4, 2);
      for (int i = 0; i < 3; i++) send_pixel(DW'($urandom));
      capture_en_i = 1'b0;
      tick();
      tick();
      chk("abort_state", deb_state_o, 0);
      chk("abort_level", fifo_level_o, exp_q.size());
      rdy_mode = 1;
      drain();
      frame_checks("abort");
      capture_en_i = 1'b1;
      tick();
      tick();
      chk("rearm_state", deb_state_o, 1);

      // reset mid-frame
      start_frame(4, 2);
      for (int i = 0; i < 3; i++) send_pixel(DW'($urandom));
      #3 rst_n_i = 1'b0;
      #1;
      chk("mrst_tvalid", m_tvalid_o, 0);
      chk("mrst_tdata", m_tdata_o, 0);
      chk("mrst_level", fifo_level_o, 0);
      chk("mrst_state", deb_state_o, 0);
      chk("mrst_frame_cnt", frame_cnt_o, 0);
      chk("mrst_flags", {ovf_o, err_o, frame_done_o, m_tuser_o, m_tlast_o}, 0);
      exp_q.delete();
      exp_frames = 0;
      seen_done = 0;
      exp_err = 1'b0;
      exp_ovf = 1'b0;
      sns_clk_roi_i = 1'b0;
      sns_enable_roi_i = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
      tick();
      tick();
      chk("post_rst_armed", deb_state_o, 1);
      start_frame(4, 2);
      for (int i = 0; i < 8; i++) send_pixel(DW'($urandom));
      end_frame();
      drain();
      frame_checks("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/roi_pixel_capture.md
ROI_PIXEL_CAPTURE -- requirements
Module: roi_pixel_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, ADC pixel width (1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of two, >=4).
REQ-003 SHALL have ports: clk_i  in  1  master clock; one clock domain, all ports synchronous to it.
REQ-004 SHALL have ports: rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: capture_en_i  in  1  enable frame capture.
REQ-006 SHALL have ports: clr_i  in  1  clear sticky status flags.
REQ-007 SHALL have ports: cfg_cols_i  in  10  pixels per line; cfg_rows_i  in  10  lines per frame.
REQ-008 SHALL have ports: sns_clk_roi_i  in  1  ROI readout clock, clk_i-registered level.
REQ-009 SHALL have ports: sns_enable_roi_i  in  1  sensor frame-valid; adc_data_i  in  DATA_WIDTH  pixel sample.
REQ-010 SHALL have ports: m_tdata_o  out  16  zero-extended pixel; m_tvalid_o  out  1; m_tready_i  in  1; m_tuser_o  out  1  start of frame; m_tlast_o  out  1  end of line.
REQ-011 SHALL have ports: frame_done_o  out  1  one-cycle pulse; frame_cnt_o  out  16; ovf_o  out  1; err_o  out  1; fifo_level_o  out  $clog2(FIFO_DEPTH)+1; deb_state_o  out  2.

Function
REQ-012 SHALL register sns_clk_roi_i once; sample event = registered value 1 and current value 0 (ROI clock falling edge).
REQ-013 SHALL use FSM states IDLE(0), ARMED(1), ACTIVE(2), DONE(3), exposed on deb_state_o.
REQ-014 IDLE -> ARMED when capture_en_i=1; any state -> IDLE when capture_en_i=0 (counters cleared, FIFO contents kept and drained).
REQ-015 ARMED -> ACTIVE on a sample event with sns_enable_roi_i=1; that sample is the first pixel; cfg_cols_i/cfg_rows_i latched at this transition.
REQ-016 In ACTIVE, each sample event with sns_enable_roi_i=1 is a pixel; a sample event with sns_enable_roi_i=0 -> DONE.
REQ-017 DONE lasts one cycle, pulses frame_done_o, increments frame_cnt_o (16-bit, wraps 0xFFFF->0), returns to ARMED.
REQ-018 Latched cfg value 0 SHALL be treated as 1.
REQ-019 Column counter wraps at cols-1; pixel with column cols-1 carries tlast=1 and increments row counter.
REQ-020 First pixel of frame carries tuser=1; all others tuser=0.
REQ-021 Pixels beyond cols*rows SHALL be dropped and set err_o.
REQ-022 Frame ending with fewer than cols*rows pixels SHALL set err_o at DONE.
REQ-023 Pixel written to FIFO as {tuser, tlast, data} at the clock edge ending the sample-event cycle; first-word-fall-through: m_tvalid_o high the next cycle when FIFO was empty.
REQ-024 Output beat transfers when m_tvalid_o and m_tready_i both 1; m_tdata_o/m_tuser_o/m_tlast_o stable while m_tvalid_o=1 and m_tready_i=0.
REQ-025 Write when FIFO full (level = FIFO_DEPTH before any same-cycle read) SHALL drop the pixel and set ovf_o; counters still advance.
REQ-026 Simultaneous read and write with FIFO not full: level unchanged.
REQ-027 ovf_o and err_o sticky; cleared by clr_i; a set event in the same cycle as clr_i wins.
REQ-028 fifo_level_o SHALL equal stored entries, 0..FIFO_DEPTH.

Reset
REQ-029 On rst_n_i=0 asynchronously: state IDLE, FIFO empty, m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, m_tlast_o=0, frame_done_o=0, frame_cnt_o=0, ovf_o=0, err_o=0, fifo_level_o=0, edge register 0.
REQ-030 Reset release SHALL produce no sample event until a true 1->0 ROI clock transition is seen after release.
REQ-031 Reset mid-frame SHALL discard partial frame and FIFO contents.

Verification
REQ-032 cols=4, rows=2, tready=1, 8 pixels 0x001..0x008 -> 8 beats in order, tuser on beat 1, tlast on beats 4 and 8, one frame_done_o, frame_cnt_o=1, err_o=0.
REQ-033 cols=4, rows=2, tready=0, 20 pixels -> fifo_level_o=16, ovf_o=1, err_o=1; then tready=1 -> exactly 16 beats out.
REQ-034 cols=4, rows=2, frame of 5 pixels -> err_o=1 at DONE, beat 4 tlast=1, beat 5 tlast=0; clr_i -> err_o=0.
REQ-035 tready toggled every cycle during 8-pixel frame -> no loss, no duplication, data held stable while stalled.
REQ-036 rst_n_i low after pixel 3 of a frame -> all outputs at reset values immediately; next full frame captured correctly with tuser on first beat.
REQ-037 capture_en_i=0 mid-frame -> deb_state_o=0, no frame_done_o, queued beats still drain.
